// File: rtl/lsu_pkg.sv
// Shared encodings, FSM state type and access-legality helper for the load/store unit.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} lsu_state_t;

  // True when the access must be rejected without touching memory.
  function automatic logic access_error(input logic [1:0]  size,
                                        input logic [31:0] addr,
                                        input logic [31:0] limit);
    logic misaligned;
    misaligned = (size == SZ_HALF && addr[0]) ||
                 (size == SZ_WORD && addr[1:0] != 2'b00);
    return misaligned || (size == 2'd3) || (addr >= limit);
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Execute-stage request/response channel and the word-wide data-memory bus.
interface lsu_req_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (output req_valid, req_is_store, req_size, req_unsigned, req_addr, req_wdata,
                  input  req_ready, resp_valid, resp_rdata, resp_err);
  modport slave  (input  req_valid, req_is_store, req_size, req_unsigned, req_addr, req_wdata,
                  output req_ready, resp_valid, resp_rdata, resp_err);
endinterface

interface lsu_mem_if;
  logic        mem_read_flag;
  logic        mem_write_flag;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (output mem_read_flag, mem_write_flag, mem_addr, mem_wdata,
                  input  mem_rdata);
  modport slave  (input  mem_read_flag, mem_write_flag, mem_addr, mem_wdata,
                  output mem_rdata);
endinterface

// File: rtl/lsu_align.sv
// Little-endian lane extraction with sign/zero extension, and sub-word store merge.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        is_unsigned,
  input  logic [31:0] rword,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  assign byte_val = rword[{addr_lo, 3'b000} +: 8];
  assign half_val = addr_lo[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    load_data = rword;
    merged    = rword;
    case (size)
      SZ_BYTE: begin
        load_data = {{24{~is_unsigned & byte_val[7]}}, byte_val};
        merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_data = {{16{~is_unsigned & half_val[15]}}, half_val};
        merged[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator: READ/WRITE strobes, read-modify-write for sub-word stores.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 32
) (
  input  logic      clk,
  input  logic      rst,
  lsu_req_if.slave  req,
  lsu_mem_if.master mem
);

  localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);

  lsu_state_t  state;
  logic        is_store_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [1:0]  addr_lo_q;
  logic [31:0] wdata_q;

  logic        resp_valid_r, resp_err_r, read_flag_r, write_flag_r;
  logic [31:0] resp_rdata_r, mem_addr_r, mem_wdata_r;
  logic [31:0] load_data, merged;

  lsu_align u_align (
    .size        (size_q),
    .addr_lo     (addr_lo_q),
    .is_unsigned (unsigned_q),
    .rword       (mem.mem_rdata),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .merged      (merged)
  );

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state        <= IDLE;
      is_store_q   <= 1'b0;
      size_q       <= 2'd0;
      unsigned_q   <= 1'b0;
      addr_lo_q    <= 2'd0;
      wdata_q      <= '0;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_rdata_r <= '0;
      read_flag_r  <= 1'b0;
      write_flag_r <= 1'b0;
      mem_addr_r   <= '0;
      mem_wdata_r  <= '0;
    end else begin
      case (state)
        IDLE: if (req.req_valid) begin
          is_store_q   <= req.req_is_store;
          size_q       <= req.req_size;
          unsigned_q   <= req.req_unsigned;
          addr_lo_q    <= req.req_addr[1:0];
          wdata_q      <= req.req_wdata;
          mem_addr_r   <= {req.req_addr[31:2], 2'b00};
          resp_rdata_r <= '0;
          if (access_error(req.req_size, req.req_addr, MEM_BYTES)) begin
            state        <= RESP;
            resp_valid_r <= 1'b1;
            resp_err_r   <= 1'b1;
          end else if (req.req_is_store && req.req_size == SZ_WORD) begin
            state        <= WRITE;
            write_flag_r <= 1'b1;
            mem_wdata_r  <= req.req_wdata;
          end else begin
            state       <= READ;
            read_flag_r <= 1'b1;
          end
        end
        READ: begin
          read_flag_r <= 1'b0;
          if (is_store_q) begin
            state        <= WRITE;
            write_flag_r <= 1'b1;
            mem_wdata_r  <= merged;
          end else begin
            state        <= RESP;
            resp_valid_r <= 1'b1;
            resp_rdata_r <= load_data;
          end
        end
        WRITE: begin
          write_flag_r <= 1'b0;
          state        <= RESP;
          resp_valid_r <= 1'b1;
        end
        default: begin
          state        <= IDLE;
          resp_valid_r <= 1'b0;
          resp_err_r   <= 1'b0;
          resp_rdata_r <= '0;
        end
      endcase
    end
  end

  assign req.req_ready      = (state == IDLE);
  assign req.resp_valid     = resp_valid_r;
  assign req.resp_err       = resp_err_r;
  assign req.resp_rdata     = resp_rdata_r;
  assign mem.mem_read_flag  = read_flag_r;
  assign mem.mem_write_flag = write_flag_r;
  assign mem.mem_addr       = mem_addr_r;
  assign mem.mem_wdata      = mem_wdata_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a 32-word behavioural data memory.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic preload = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [31:0] mem_model [32];

  lsu_req_if req_bus ();
  lsu_mem_if mem_bus ();

  load_store_unit #(.MEM_WORDS(32)) dut (
    .clk (clk),
    .rst (rst),
    .req (req_bus.slave),
    .mem (mem_bus.master)
  );

  always #5 clk = ~clk;

  assign mem_bus.mem_rdata = mem_model[mem_bus.mem_addr[6:2]];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) mem_model[i] <= 32'h0;
      mem_model[0] <= 32'h0000000F;
      mem_model[1] <= 32'h0000000C;
    end else if (mem_bus.mem_write_flag && !rst) begin
      mem_model[mem_bus.mem_addr[6:2]] <= mem_bus.mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Results of the most recent transaction.
  int          lat, n_rd, n_wr;
  logic [31:0] rd_addr, wr_data, rsp_data;
  logic        rsp_err, both_seen;

  task automatic do_req(input logic st, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd);
    logic got;
    @(negedge clk);
    req_bus.req_is_store = st;
    req_bus.req_size     = sz;
    req_bus.req_unsigned = uns;
    req_bus.req_addr     = a;
    req_bus.req_wdata    = wd;
    req_bus.req_valid    = 1'b1;
    @(posedge clk);
    #1 req_bus.req_valid = 1'b0;
    lat = 0; n_rd = 0; n_wr = 0; got = 1'b0; both_seen = 1'b0;
    rd_addr = 'x; wr_data = 'x; rsp_data = 'x; rsp_err = 1'bx;
    for (int c = 1; c <= 8 && !got; c++) begin
      @(negedge clk);
      if (mem_bus.mem_read_flag)  begin n_rd++; rd_addr = mem_bus.mem_addr; end
      if (mem_bus.mem_write_flag) begin n_wr++; wr_data = mem_bus.mem_wdata; end
      if (mem_bus.mem_read_flag && mem_bus.mem_write_flag) both_seen = 1'b1;
      if (req_bus.resp_valid) begin
        got = 1'b1; lat = c;
        rsp_data = req_bus.resp_rdata; rsp_err = req_bus.resp_err;
      end
    end
  endtask

  task automatic check_err(input string tag);
    check({tag, " latency"}, 32'(lat), 32'd1);
    check({tag, " err"}, {31'b0, rsp_err}, 32'd1);
    check({tag, " rdata"}, rsp_data, 32'h0);
    check({tag, " strobes"}, 32'(n_rd + n_wr), 32'd0);
  endtask

  initial begin
    int bad_wr, bad_rv;
    req_bus.req_valid    = 1'b0;
    req_bus.req_is_store = 1'b0;
    req_bus.req_size     = SZ_WORD;
    req_bus.req_unsigned = 1'b0;
    req_bus.req_addr     = '0;
    req_bus.req_wdata    = '0;

    repeat (2) @(negedge clk);
    check("reset resp_valid", {31'b0, req_bus.resp_valid}, 32'd0);
    check("reset resp_err",   {31'b0, req_bus.resp_err}, 32'd0);
    check("reset resp_rdata", req_bus.resp_rdata, 32'h0);
    check("reset strobes",    {30'b0, mem_bus.mem_read_flag, mem_bus.mem_write_flag}, 32'd0);
    check("reset mem_addr",   mem_bus.mem_addr, 32'h0);
    check("reset mem_wdata",  mem_bus.mem_wdata, 32'h0);
    check("reset ready",      {31'b0, req_bus.req_ready}, 32'd1);
    rst = 1'b0;
    preload = 1'b0;

    // Word load
    do_req(1'b0, SZ_WORD, 1'b0, 32'h4, 32'h0);
    check("lw latency", 32'(lat), 32'd2);
    check("lw rdata", rsp_data, 32'h0000000C);
    check("lw err", {31'b0, rsp_err}, 32'd0);
    check("lw reads", 32'(n_rd), 32'd1);
    check("lw rd_addr", rd_addr, 32'h4);
    check("lw writes", 32'(n_wr), 32'd0);

    // Byte store and signed/unsigned byte loads
    do_req(1'b1, SZ_BYTE, 1'b0, 32'h9, 32'h00000080);
    check("sb latency", 32'(lat), 32'd3);
    check("sb reads", 32'(n_rd), 32'd1);
    check("sb writes", 32'(n_wr), 32'd1);
    check("sb wdata", wr_data, 32'h00008000);
    check("sb rdata", rsp_data, 32'h0);
    check("sb err", {31'b0, rsp_err}, 32'd0);
    do_req(1'b0, SZ_BYTE, 1'b0, 32'h9, 32'h0);
    check("lb signed", rsp_data, 32'hFFFFFF80);
    check("lb latency", 32'(lat), 32'd2);
    do_req(1'b0, SZ_BYTE, 1'b1, 32'h9, 32'h0);
    check("lbu", rsp_data, 32'h00000080);

    // Half store into upper lane, then half loads
    do_req(1'b1, SZ_HALF, 1'b0, 32'h2, 32'h1234BEEF);
    check("sh latency", 32'(lat), 32'd3);
    check("sh wdata", wr_data, 32'hBEEF000F);
    check("sh no overlap", {31'b0, both_seen}, 32'd0);
    check("sh mem word0", mem_model[0], 32'hBEEF000F);
    do_req(1'b0, SZ_HALF, 1'b0, 32'h2, 32'h0);
    check("lh signed", rsp_data, 32'hFFFFBEEF);
    do_req(1'b0, SZ_HALF, 1'b1, 32'h0, 32'h0);
    check("lhu", rsp_data, 32'h0000000F);

    // Error cases and the last legal word
    do_req(1'b0, SZ_WORD, 1'b0, 32'h6, 32'h0);
    check_err("lw misaligned");
    do_req(1'b0, SZ_HALF, 1'b0, 32'h3, 32'h0);
    check_err("lh misaligned");
    do_req(1'b0, 2'd3, 1'b0, 32'h0, 32'h0);
    check_err("reserved size");
    do_req(1'b0, SZ_WORD, 1'b0, 32'h80, 32'h0);
    check_err("out of range");
    do_req(1'b1, SZ_BYTE, 1'b0, 32'h80, 32'hFF);
    check_err("sb out of range");
    do_req(1'b0, SZ_WORD, 1'b0, 32'h7C, 32'h0);
    check("lw last word err", {31'b0, rsp_err}, 32'd0);
    check("lw last word latency", 32'(lat), 32'd2);

    // Back-to-back word stores with req_valid held high
    @(negedge clk);
    req_bus.req_is_store = 1'b1;
    req_bus.req_size     = SZ_WORD;
    req_bus.req_addr     = 32'h10;
    req_bus.req_wdata    = 32'hA5A5_0001;
    req_bus.req_valid    = 1'b1;
    @(posedge clk);
    #1;
    req_bus.req_addr  = 32'h14;
    req_bus.req_wdata = 32'h5A5A_0002;
    @(negedge clk);
    check("b2b c1 ready", {31'b0, req_bus.req_ready}, 32'd0);
    check("b2b c1 write", {31'b0, mem_bus.mem_write_flag}, 32'd1);
    @(negedge clk);
    check("b2b c2 resp", {31'b0, req_bus.resp_valid}, 32'd1);
    check("b2b c2 ready", {31'b0, req_bus.req_ready}, 32'd0);
    @(negedge clk);
    check("b2b c3 ready", {31'b0, req_bus.req_ready}, 32'd1);
    check("b2b c3 resp", {31'b0, req_bus.resp_valid}, 32'd0);
    @(posedge clk);
    #1 req_bus.req_valid = 1'b0;
    @(negedge clk);
    check("b2b c4 ready", {31'b0, req_bus.req_ready}, 32'd0);
    check("b2b c4 write", {31'b0, mem_bus.mem_write_flag}, 32'd1);
    check("b2b c4 addr", mem_bus.mem_addr, 32'h14);
    @(negedge clk);
    check("b2b c5 resp", {31'b0, req_bus.resp_valid}, 32'd1);
    check("b2b mem word4", mem_model[4], 32'hA5A5_0001);
    check("b2b mem word5", mem_model[5], 32'h5A5A_0002);

    // Reset while a byte store is in READ
    @(negedge clk);
    req_bus.req_is_store = 1'b1;
    req_bus.req_size     = SZ_BYTE;
    req_bus.req_addr     = 32'hA;
    req_bus.req_wdata    = 32'h55;
    req_bus.req_valid    = 1'b1;
    @(posedge clk);
    #1 req_bus.req_valid = 1'b0;
    @(negedge clk);
    check("abort in read", {31'b0, mem_bus.mem_read_flag}, 32'd1);
    rst = 1'b1;
    #1;
    check("abort read drop", {31'b0, mem_bus.mem_read_flag}, 32'd0);
    bad_wr = 0; bad_rv = 0;
    repeat (2) begin
      @(negedge clk);
      if (mem_bus.mem_write_flag) bad_wr++;
      if (req_bus.resp_valid) bad_rv++;
    end
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (mem_bus.mem_write_flag) bad_wr++;
      if (req_bus.resp_valid) bad_rv++;
    end
    check("abort writes", 32'(bad_wr), 32'd0);
    check("abort resp", 32'(bad_rv), 32'd0);
    check("abort ready", {31'b0, req_bus.req_ready}, 32'd1);
    check("abort mem word2", mem_model[2], 32'h00008000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
